// File: rtl/sa_pkg.sv
// sa_pkg: shared defaults, FSM state encoding and a lane-slice helper for the
// systolic-array skew feeder.
package sa_pkg;

  localparam int SA_DATA_W = 64;
  localparam int SA_N      = 4;
  localparam int SA_CNT_W  = 4;

  // IDLE: waiting for the first slice of a tile.
  // FEED: mid-tile, slices (or bubbles) being injected.
  // DRAIN: last slice taken, chains flush until the far PE has its operands.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } sa_state_t;

  // Extract element idx from a packed lane bus (element idx at idx*W +: W).
  function automatic logic [SA_DATA_W-1:0] lane_slice(
    input logic [SA_N*SA_DATA_W-1:0] lanes,
    input int                        idx
  );
    return lanes[idx*SA_DATA_W +: SA_DATA_W];
  endfunction

endpackage

// File: rtl/sa_skew_feeder_if.sv
// sa_skew_feeder_if: slice input handshake plus skewed lane outputs of the
// feeder. Optional macro SA_FEED_BACKPRESSURE_EN adds out_ready.
//
// Handshake: a slice (in_a, in_b, in_last) transfers on a rising clock edge
// where in_valid && in_ready are both high. in_valid may rise at any time;
// in_a/in_b/in_last are only looked at on a transfer edge. in_ready does not
// depend on in_valid.
interface sa_skew_feeder_if #(
  parameter int DATA_W = sa_pkg::SA_DATA_W,
  parameter int N      = sa_pkg::SA_N
) ();
  import sa_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                in_last;
  logic [N*DATA_W-1:0] in_a;
  logic [N*DATA_W-1:0] in_b;
  logic [N*DATA_W-1:0] a_lane;
  logic [N*DATA_W-1:0] b_lane;
  logic [N-1:0]        lane_vld;
  logic                tile_start;
  logic                tile_done;
  logic                busy;
  sa_state_t           fsm_state;
`ifdef SA_FEED_BACKPRESSURE_EN
  logic                out_ready;

  modport slave (
    input  in_valid, in_last, in_a, in_b, out_ready,
    output in_ready, a_lane, b_lane, lane_vld, tile_start, tile_done, busy,
           fsm_state
  );
  modport master (
    output in_valid, in_last, in_a, in_b, out_ready,
    input  in_ready, a_lane, b_lane, lane_vld, tile_start, tile_done, busy,
           fsm_state
  );
`else
  modport slave (
    input  in_valid, in_last, in_a, in_b,
    output in_ready, a_lane, b_lane, lane_vld, tile_start, tile_done, busy,
           fsm_state
  );
  modport master (
    output in_valid, in_last, in_a, in_b,
    input  in_ready, a_lane, b_lane, lane_vld, tile_start, tile_done, busy,
           fsm_state
  );
`endif

endinterface

// File: rtl/sa_delay_line.sv
// sa_delay_line: DEPTH-stage shift register carrying {vld, data}; advances
// only when en is high, clears asynchronously on rst.
module sa_delay_line #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DATA_W:0] d,
  output logic [DATA_W:0] q
);

  logic [DATA_W:0] stage [DEPTH];

  // Shift one stage per enabled cycle; hold everything when en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
    end else if (en) begin
      stage[0] <= d;
      for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: takes one k-slice (column of A, row of B) per handshake and
// drives the systolic array edge lanes with diagonal skew (lane i delayed by
// i extra cycles, zero bubbles when idle). Pulses tile_start when lane 0
// shows a tile's first slice and tile_done once PE(N-1,N-1) has its last pair.
// Optional macro SA_FEED_BACKPRESSURE_EN adds out_ready, which freezes the
// whole feeder while low.
module sa_skew_feeder #(
  parameter int DATA_W = sa_pkg::SA_DATA_W,
  parameter int N      = sa_pkg::SA_N,
  parameter int CNT_W  = sa_pkg::SA_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  sa_skew_feeder_if.slave bus
);
  import sa_pkg::*;

  // Last operand pair reaches PE(N-1,N-1) 2N-1 cycles after the last slice
  // edge; counting 2N-2 down to 0 in DRAIN lands tile_done on that cycle.
  // Assumes N >= 2 so the pulse can be raised on the cnt==1 -> 0 step.
  localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(2*N-2);

  sa_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             tile_start_q;
  logic             tile_done_q;
  logic             adv;
  logic             hs;

`ifdef SA_FEED_BACKPRESSURE_EN
  assign adv = bus.out_ready;
`else
  assign adv = 1'b1;
`endif

  assign bus.in_ready   = (state != DRAIN) && adv;
  assign hs             = bus.in_valid && bus.in_ready;
  assign bus.busy       = (state != IDLE);
  // Pulses are held through stalls and only shown on an advancing cycle, so
  // each appears exactly once.
  assign bus.tile_start = tile_start_q && adv;
  assign bus.tile_done  = tile_done_q && adv;
  assign bus.fsm_state  = state;

  // Tile-boundary FSM with drain counter and registered boundary pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      tile_start_q <= 1'b0;
      tile_done_q  <= 1'b0;
    end else if (adv) begin
      tile_start_q <= 1'b0;
      tile_done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            tile_start_q <= 1'b1;
            if (bus.in_last) begin
              state <= DRAIN;
              cnt   <= DRAIN_LEN;
            end else begin
              state <= FEED;
            end
          end
        end
        FEED: begin
          if (hs && bus.in_last) begin
            state <= DRAIN;
            cnt   <= DRAIN_LEN;
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
          if (cnt == CNT_W'(1)) tile_done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane i: i+1 register stages for both A and B so a and b stay aligned at
  // every PE; non-handshake cycles inject a zero bubble with vld=0.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W:0] a_d, a_q, b_d, b_q;

    assign a_d = hs ? {1'b1, bus.in_a[i*DATA_W +: DATA_W]} : '0;
    assign b_d = hs ? {1'b1, bus.in_b[i*DATA_W +: DATA_W]} : '0;

    sa_delay_line #(.DATA_W(DATA_W), .DEPTH(i+1)) u_a_dly (
      .clk (clk),
      .rst (rst),
      .en  (adv),
      .d   (a_d),
      .q   (a_q)
    );

    sa_delay_line #(.DATA_W(DATA_W), .DEPTH(i+1)) u_b_dly (
      .clk (clk),
      .rst (rst),
      .en  (adv),
      .d   (b_d),
      .q   (b_q)
    );

    assign bus.a_lane[i*DATA_W +: DATA_W] = a_q[DATA_W-1:0];
    assign bus.b_lane[i*DATA_W +: DATA_W] = b_q[DATA_W-1:0];
    assign bus.lane_vld[i]                = a_q[DATA_W] & b_q[DATA_W];
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// tb_sa_skew_feeder: directed bench for sa_skew_feeder with a behavioural
// 4x4 output-stationary array model fed from the lane outputs.
// Optional macro SA_FEED_BACKPRESSURE_EN enables the out_ready sequence.
module tb_sa_skew_feeder;
  import sa_pkg::*;

  localparam int DW = 64;
  localparam int NN = 4;

  logic clk;
  logic rst;

  sa_skew_feeder_if #(.DATA_W(DW), .N(NN)) bus ();

  sa_skew_feeder #(.DATA_W(DW), .N(NN), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int nchk = 0;
  int nerr = 0;

  // ---------------- array model ----------------
  logic stall;
`ifdef SA_FEED_BACKPRESSURE_EN
  assign stall = !bus.out_ready;
`else
  assign stall = 1'b0;
`endif

  logic [DW-1:0] pa  [NN][NN];
  logic [DW-1:0] pb  [NN][NN];
  logic [DW-1:0] acc [NN][NN];
  logic [DW-1:0] ain, bin;

  // Each PE multiplies its left/top inputs, accumulates, and forwards them.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NN; i++)
        for (int j = 0; j < NN; j++) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end
    end else if (!stall) begin
      for (int i = 0; i < NN; i++)
        for (int j = 0; j < NN; j++) begin
          ain = (j == 0) ? lane_slice(bus.a_lane, i) : pa[i][(j == 0) ? 0 : j-1];
          bin = (i == 0) ? lane_slice(bus.b_lane, j) : pb[(i == 0) ? 0 : i-1][j];
          pa[i][j]  <= ain;
          pb[i][j]  <= bin;
          acc[i][j] <= (bus.tile_start ? '0 : acc[i][j]) + ain * bin;
        end
    end
  end

  // ---------------- monitors ----------------
  logic [NN-1:0] vld_log[$];
  int td_cnt = 0;
  int ts_cnt = 0;
  int hs_cnt = 0;

  always @(negedge clk) begin
    vld_log.push_back(bus.lane_vld);
    if (bus.tile_done)  td_cnt++;
    if (bus.tile_start) ts_cnt++;
  end

  always @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) hs_cnt++;
  end

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [255:0] mk(input logic [63:0] e3, e2, e1, e0);
    return {e3, e2, e1, e0};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a slice at the next negedge; returns just after the edge it is taken on.
  task automatic send_slice(input logic [255:0] a, input logic [255:0] b, input logic last);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
  endtask

  // Count negedges after the last slice edge until tile_done (bounded).
  task automatic wait_done(input bit keep, output int n_done, output int n_start);
    n_done  = 0;
    n_start = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!keep && n == 1) bus.in_valid = 1'b0;
      if (bus.tile_start && n_start == 0) n_start = n;
      if (bus.tile_done) begin
        n_done = n;
        break;
      end
    end
    if (n_done == 0) begin
      nchk++;
      nerr++;
      $display("FAIL wait_done: no tile_done within 40 cycles");
    end
  endtask

  // A = I, so the array result must equal B[i][j] = 4i+j+1.
  task automatic check_y(input string tag);
    for (int i = 0; i < NN; i++)
      for (int j = 0; j < NN; j++)
        chk($sformatf("%s_y%0d%0d", tag, i, j), acc[i][j], 256'(4*i + j + 1));
  endtask

  task automatic slice_k(input int k, output logic [255:0] a, output logic [255:0] b);
    a = '0;
    b = '0;
    a[k*DW +: DW] = 64'd1;
    for (int j = 0; j < NN; j++) b[j*DW +: DW] = 64'(4*k + j + 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [255:0] a;
    logic [255:0] b;
    logic [3:0]   vld;
    logic         ts;
    logic         td;
    logic         busy;
    logic         rdy;
  } vec_t;

  vec_t tbl[8];
  logic [NN-1:0] exp_q[$];

  initial begin
    logic [255:0] sa, sb;
    int nd, ns, base, td0, ts0, hs0;
    int edges[4];

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
`ifdef SA_FEED_BACKPRESSURE_EN
    bus.out_ready = 1'b1;
`endif

    // Single slice a={4,3,2,1}, b={8,7,6,5}, in_last=1; rows are cycles 1..8.
    tbl[0] = '{mk(0,0,0,1), mk(0,0,0,5), 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{mk(0,0,2,0), mk(0,0,6,0), 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{mk(0,3,0,0), mk(0,7,0,0), 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{mk(4,0,0,0), mk(8,0,0,0), 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{256'd0,      256'd0,      4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{256'd0,      256'd0,      4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{256'd0,      256'd0,      4'b0000, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{256'd0,      256'd0,      4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_a_lane", bus.a_lane, '0);
    chk("rst_b_lane", bus.b_lane, '0);
    chk("rst_vld", bus.lane_vld, '0);
    chk("rst_tile_start", bus.tile_start, '0);
    chk("rst_tile_done", bus.tile_done, '0);
    chk("rst_busy", bus.busy, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);

    // ---- single slice, table driven ----
    send_slice(mk(4,3,2,1), mk(8,7,6,5), 1'b1);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      if (r == 0) bus.in_valid = 1'b0;
      chk($sformatf("single_c%0d_a", r+1), bus.a_lane, tbl[r].a);
      chk($sformatf("single_c%0d_b", r+1), bus.b_lane, tbl[r].b);
      chk($sformatf("single_c%0d_vld", r+1), bus.lane_vld, tbl[r].vld);
      chk($sformatf("single_c%0d_ts", r+1), bus.tile_start, tbl[r].ts);
      chk($sformatf("single_c%0d_td", r+1), bus.tile_done, tbl[r].td);
      chk($sformatf("single_c%0d_busy", r+1), bus.busy, tbl[r].busy);
      chk($sformatf("single_c%0d_rdy", r+1), bus.in_ready, tbl[r].rdy);
    end

    // ---- K=4 back-to-back, then in_valid held high through DRAIN ----
    hs0 = hs_cnt;
    for (int k = 0; k < 4; k++) begin
      slice_k(k, sa, sb);
      send_slice(sa, sb, (k == 3));
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = mk(1,1,1,1);
    bus.in_b     = mk(2,2,2,2);
    bus.in_last  = 1'b1;
    chk("k4_drain_rdy", bus.in_ready, 0);
    wait_done(1'b1, nd, ns);
    chk("k4_done_cycle", nd, 7 - 1);
    @(negedge clk);
    check_y("k4");
    chk("k4_rdy_after_done", bus.in_ready, 1);
    chk("k4_no_accept_in_drain", hs_cnt - hs0, 4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("k4_next_tile_start", bus.tile_start, 1);
    chk("k4_next_accepted", hs_cnt - hs0, 5);
    wait_done(1'b0, nd, ns);
    chk("k4_next_done_cycle", nd, 6);

    // ---- bubble mid-tile: slices taken at edges 0,1,4,5 ----
    edges = '{0, 1, 4, 5};
    slice_k(0, sa, sb);
    send_slice(sa, sb, 1'b0);
    base = vld_log.size();
    slice_k(1, sa, sb);
    send_slice(sa, sb, 1'b0);
    idle_cycle();
    idle_cycle();
    slice_k(2, sa, sb);
    send_slice(sa, sb, 1'b0);
    slice_k(3, sa, sb);
    send_slice(sa, sb, 1'b1);
    wait_done(1'b0, nd, ns);
    chk("bubble_done_cycle", nd, 7);
    @(negedge clk);
    check_y("bubble");
    for (int c = 1; c <= 9; c++) begin
      logic [NN-1:0] v;
      v = '0;
      for (int e = 0; e < 4; e++)
        for (int i = 0; i < NN; i++)
          if (c == edges[e] + 1 + i) v[i] = 1'b1;
      exp_q.push_back(v);
    end
    for (int c = 1; c <= 9; c++) begin
      logic [NN-1:0] ev;
      ev = exp_q.pop_front();
      chk($sformatf("bubble_vld_c%0d", c), vld_log[base + c - 1], ev);
    end

    // ---- reset mid-DRAIN ----
    td0 = td_cnt;
    send_slice(mk(4,3,2,1), mk(8,7,6,5), 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) bus.in_valid = 1'b0;
    end
    chk("mid_pre_a_lane", bus.a_lane, mk(4,0,0,0));
    rst = 1'b1;
    #1;
    chk("mid_rst_a_lane", bus.a_lane, '0);
    chk("mid_rst_b_lane", bus.b_lane, '0);
    chk("mid_rst_vld", bus.lane_vld, '0);
    chk("mid_rst_busy", bus.busy, '0);
    chk("mid_rst_td", bus.tile_done, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_rst_no_done", td_cnt - td0, 0);
    send_slice(mk(4,3,2,1), mk(8,7,6,5), 1'b1);
    wait_done(1'b0, nd, ns);
    chk("post_rst_ts_cycle", ns, 1);
    chk("post_rst_done_cycle", nd, 7);

`ifdef SA_FEED_BACKPRESSURE_EN
    // ---- out_ready low 3 cycles during FEED ----
    td0 = td_cnt;
    ts0 = ts_cnt;
    send_slice(mk(8'h44, 8'h33, 8'h22, 8'h11), mk(5,5,5,5), 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_ts", bus.tile_start, 1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_last   = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      if (c > 2) @(negedge clk);
      chk($sformatf("bp_frozen_a_c%0d", c), bus.a_lane, mk(0, 0, 8'h22, 0));
      chk($sformatf("bp_frozen_vld_c%0d", c), bus.lane_vld, 4'b0010);
      chk($sformatf("bp_rdy_c%0d", c), bus.in_ready, 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    wait_done(1'b0, nd, ns);
    chk("bp_done_cycle", 5 + nd, 12);
    @(negedge clk);
    chk("bp_single_done", td_cnt - td0, 1);
    chk("bp_single_start", ts_cnt - ts0, 1);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
